// File: rtl/alu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | alu_pkg : opcode encodings shared by the pipelined ALU          |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
package alu_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD   = 6'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd1;
  localparam logic [OP_W-1:0] OP_SHL   = 6'd2;
  localparam logic [OP_W-1:0] OP_SHR   = 6'd3;
  localparam logic [OP_W-1:0] OP_MOV   = 6'd4;
  localparam logic [OP_W-1:0] OP_LDLO  = 6'd5;
  localparam logic [OP_W-1:0] OP_LDHI  = 6'd6;
  localparam logic [OP_W-1:0] OP_CMPEQ = 6'd7;
  localparam logic [OP_W-1:0] OP_CMPLT = 6'd8;
  localparam logic [OP_W-1:0] OP_CMPGT = 6'd9;
  localparam logic [OP_W-1:0] OP_FNOT  = 6'd10;
  localparam logic [OP_W-1:0] OP_FAND  = 6'd11;
  localparam logic [OP_W-1:0] OP_JMP   = 6'd12;
  localparam logic [OP_W-1:0] OP_JMPF  = 6'd13;

endpackage
`default_nettype wire

// File: rtl/alu_pipe_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | alu_pipe_if : operand/result handshake bundle of alu_pipe       |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface alu_pipe_if #(
  parameter int WIDTH = 32,
  parameter int IMM_W = WIDTH / 2
);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [IMM_W-1:0] in_imm;
  logic [WIDTH-1:0] in_target;
  logic             in_f2;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_zero;
  logic             out_flag;
  logic             out_jump;
  logic [WIDTH-1:0] out_naddr;
  logic             out_illegal;

  // Upstream decoder plus downstream writeback stage
  modport master (
    output in_valid, in_op, in_a, in_b, in_imm, in_target, in_f2, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_zero, out_flag,
           out_jump, out_naddr, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_imm, in_target, in_f2, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_zero, out_flag,
           out_jump, out_naddr, out_illegal
  );

endinterface
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | alu_core : purely combinational opcode evaluation               |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IMM_W = WIDTH / 2,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [IMM_W-1:0] imm,
  input  logic [WIDTH-1:0] target,
  input  logic             flag,
  input  logic             f2,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             flag_next,
  output logic             jump,
  output logic [WIDTH-1:0] naddr,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] C_WIDTH_VAL = WIDTH'(WIDTH);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           shift_oor;

  // diff[WIDTH] is set exactly when a < b unsigned, i.e. the borrow
  assign sum       = {1'b0, a} + {1'b0, b};
  assign diff      = {1'b0, a} - {1'b0, b};
  assign shift_oor = (b >= C_WIDTH_VAL);

  always_comb begin
    result    = '0;
    carry     = 1'b0;
    flag_next = flag;
    jump      = 1'b0;
    naddr     = '0;
    illegal   = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
      end
      OP_SHL:   result = shift_oor ? '0 : (a << b[SHW-1:0]);
      OP_SHR:   result = shift_oor ? '0 : (a >> b[SHW-1:0]);
      OP_MOV:   result = a;
      OP_LDLO:  result = {a[WIDTH-1:IMM_W], imm};
      OP_LDHI:  result = {imm, a[IMM_W-1:0]};
      OP_CMPEQ: flag_next = (a == b);
      OP_CMPLT: flag_next = (a < b);
      OP_CMPGT: flag_next = (a > b);
      OP_FNOT:  flag_next = ~flag;
      OP_FAND:  flag_next = flag & f2;
      OP_JMP: begin
        jump  = 1'b1;
        naddr = target;
      end
      OP_JMPF: begin
        jump  = flag;
        naddr = flag ? target : '0;
      end
      default:  illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | alu_pipe : two-stage valid/ready ALU with internal flag register|
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IMM_W = WIDTH / 2,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clock,
  input  logic     reset_n,
  alu_pipe_if.slave bus
);

  logic             s2_adv;
  logic             in_ready_w;

  logic             s1_valid_q,  s1_valid_d;
  logic [OP_W-1:0]  s1_op_q,     s1_op_d;
  logic [WIDTH-1:0] s1_a_q,      s1_a_d;
  logic [WIDTH-1:0] s1_b_q,      s1_b_d;
  logic [IMM_W-1:0] s1_imm_q,    s1_imm_d;
  logic [WIDTH-1:0] s1_target_q, s1_target_d;
  logic             s1_f2_q,     s1_f2_d;

  logic             out_valid_q,   out_valid_d;
  logic [WIDTH-1:0] out_result_q,  out_result_d;
  logic             out_carry_q,   out_carry_d;
  logic             out_zero_q,    out_zero_d;
  logic             out_flag_q,    out_flag_d;
  logic             out_jump_q,    out_jump_d;
  logic [WIDTH-1:0] out_naddr_q,   out_naddr_d;
  logic             out_illegal_q, out_illegal_d;
  logic             flag_q,        flag_d;

  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic             core_flag;
  logic             core_jump;
  logic [WIDTH-1:0] core_naddr;
  logic             core_illegal;

  // The S1 op sees flag_q, which already holds the effect of every older op
  alu_core #(
    .WIDTH (WIDTH),
    .IMM_W (IMM_W),
    .SHW   (SHW)
  ) u_core (
    .op        (s1_op_q),
    .a         (s1_a_q),
    .b         (s1_b_q),
    .imm       (s1_imm_q),
    .target    (s1_target_q),
    .flag      (flag_q),
    .f2        (s1_f2_q),
    .result    (core_result),
    .carry     (core_carry),
    .flag_next (core_flag),
    .jump      (core_jump),
    .naddr     (core_naddr),
    .illegal   (core_illegal)
  );

  always_comb begin
    s2_adv     = ~out_valid_q | bus.out_ready;
    in_ready_w = ~s1_valid_q | s2_adv;

    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_imm_d    = s1_imm_q;
    s1_target_d = s1_target_q;
    s1_f2_d     = s1_f2_q;

    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_carry_d   = out_carry_q;
    out_zero_d    = out_zero_q;
    out_flag_d    = out_flag_q;
    out_jump_d    = out_jump_q;
    out_naddr_d   = out_naddr_q;
    out_illegal_d = out_illegal_q;
    flag_d        = flag_q;

    if (in_ready_w) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_op_d     = bus.in_op;
        s1_a_d      = bus.in_a;
        s1_b_d      = bus.in_b;
        s1_imm_d    = bus.in_imm;
        s1_target_d = bus.in_target;
        s1_f2_d     = bus.in_f2;
      end
    end

    // A bubble advancing into S2 only clears out_valid; fields and flag hold
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_result_d  = core_result;
        out_carry_d   = core_carry;
        out_zero_d    = (core_result == '0);
        out_flag_d    = core_flag;
        out_jump_d    = core_jump;
        out_naddr_d   = core_naddr;
        out_illegal_d = core_illegal;
        flag_d        = core_flag;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid_q    <= 1'b0;
      s1_op_q       <= '0;
      s1_a_q        <= '0;
      s1_b_q        <= '0;
      s1_imm_q      <= '0;
      s1_target_q   <= '0;
      s1_f2_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_carry_q   <= 1'b0;
      out_zero_q    <= 1'b0;
      out_flag_q    <= 1'b0;
      out_jump_q    <= 1'b0;
      out_naddr_q   <= '0;
      out_illegal_q <= 1'b0;
      flag_q        <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_op_q       <= s1_op_d;
      s1_a_q        <= s1_a_d;
      s1_b_q        <= s1_b_d;
      s1_imm_q      <= s1_imm_d;
      s1_target_q   <= s1_target_d;
      s1_f2_q       <= s1_f2_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_carry_q   <= out_carry_d;
      out_zero_q    <= out_zero_d;
      out_flag_q    <= out_flag_d;
      out_jump_q    <= out_jump_d;
      out_naddr_q   <= out_naddr_d;
      out_illegal_q <= out_illegal_d;
      flag_q        <= flag_d;
    end
  end

  assign bus.in_ready    = in_ready_w;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_carry   = out_carry_q;
  assign bus.out_zero    = out_zero_q;
  assign bus.out_flag    = out_flag_q;
  assign bus.out_jump    = out_jump_q;
  assign bus.out_naddr   = out_naddr_q;
  assign bus.out_illegal = out_illegal_q;

endmodule
`default_nettype wire

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor of the single-cycle ALU. It executes arithmetic, shift, move, half-word load, compare, flag-logic and jump operations on WIDTH-bit operands.
- Uses valid/ready handshakes on input and output, so the decoder can stall it.
- Holds the condition flag in an internal register instead of an inout line.
- Sits between the register-file read stage and the writeback/PC-update stage.

Parameters:
- WIDTH, 32, operand and result width in bits; must be even and >= 8.
- IMM_W, WIDTH/2, width of the immediate used by the half-word loads.
- SHW, $clog2(WIDTH), number of low bits of in_b used as the shift amount.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  an operation is presented on the in_* lines.
- in_ready  out  1  stage 1 can accept an operation this cycle.
- in_op  in  6  opcode.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B, or the shift amount.
- in_imm  in  IMM_W  immediate for LDLO/LDHI.
- in_target  in  WIDTH  jump target address.
- in_f2  in  1  external second flag used by FAND.
- out_valid  out  1  a result is held on the out_* lines.
- out_ready  in  1  the consumer takes the result this cycle.
- out_result  out  WIDTH  result word.
- out_carry  out  1  carry out of ADD, or borrow out of SUB; 0 for all other ops.
- out_zero  out  1  out_result == 0.
- out_flag  out  1  value of the flag register after this op.
- out_jump  out  1  the PC must be loaded from out_naddr.
- out_naddr  out  WIDTH  next PC; 0 when out_jump=0.
- out_illegal  out  1  opcode was undefined.

Behaviour:
- Clocking: one clock (clock); reset is synchronous, active-low (reset_n), applied on the rising edge of clock.
- Reset values:
  - s1_valid=0, out_valid=0, flag=0.
  - out_result=0, out_carry=0, out_zero=0, out_flag=0, out_jump=0, out_naddr=0, out_illegal=0.
  - Reset mid-operation discards both stages; no output is produced for in-flight ops.
- Pipeline:
  - S1 registers the inputs.
  - S2 computes from the S1 registers and registers every out_* field and the flag.
  - Latency is 2 cycles from acceptance (in_valid & in_ready) to out_valid, with no bubbles at full rate.
- Handshake and stalls:
  - out_ready is the only backpressure source.
  - s2_adv = !out_valid | out_ready.
  - in_ready = !s1_valid | s2_adv.
  - While out_valid=1 and out_ready=0, the out_* fields hold stable and the flag does not change.
  - in_valid may drop at any time without side effects.
- Flag register:
  - Written only when S2 advances an op, and only by CMPEQ, CMPLT, CMPGT, FNOT and FAND; all other ops leave it unchanged.
  - An op reads the flag value left by all older ops, so back-to-back flag producer and consumer need no stall.
- Opcodes (out_result / out_carry / flag / jump):
  - 0 ADD: result = a+b mod 2^WIDTH; carry = bit WIDTH of the sum.
  - 1 SUB: result = a-b in two's complement (a + ~b + 1); carry = borrow = (a<b unsigned).
  - 2 SHL: result = a << b[SHW-1:0]; if b >= WIDTH, result=0.
  - 3 SHR: logical right shift; same out-of-range rule as SHL.
  - 4 MOV: result = a.
  - 5 LDLO: result = {a[WIDTH-1:IMM_W], imm}.
  - 6 LDHI: result = {imm, a[IMM_W-1:0]}.
  - 7 CMPEQ: flag = (a==b); result = 0.
  - 8 CMPLT: flag = (a<b), unsigned; result = 0.
  - 9 CMPGT: flag = (a>b), unsigned; result = 0.
  - 10 FNOT: flag = !flag; result = 0.
  - 11 FAND: flag = flag & in_f2; result = 0.
  - 12 JMP: out_jump=1; out_naddr=target; result = 0.
  - 13 JMPF: out_jump = flag; out_naddr = flag ? target : 0; result = 0.
  - 14-63: out_illegal=1; result=0; flag unchanged; no jump.
- out_zero is computed on the final out_result for every op, including ops with forced result 0, where out_zero=1.

Decomposition:
- Package alu_pkg holds the opcode localparams (OP_ADD..OP_JMPF) and OP_W=6.
- One combinational sub-module, alu_core, maps (op, a, b, imm, target, flag, f2) to (result, carry, flag_next, jump, naddr, illegal).
- alu_pipe holds the S1/S2 registers, the handshake logic and the flag register.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with in_valid=1 -> out_valid=0, flag=0, all out_* = 0; the first op after release appears 2 cycles after acceptance.
- Arithmetic, WIDTH=32: ADD 0xFFFFFFFF+1 -> result 0, carry 1, zero 1. SUB 3-5 -> 0xFFFFFFFE, carry 1. SHL 1 by 31 -> 0x80000000. SHR by 40 -> 0.
- Loads: LDLO a=0x12345678 imm=0xBEEF -> 0x1234BEEF. LDHI with the same inputs -> 0xBEEF5678.
- Flag chain with no bubbles: CMPLT 2<7, then FNOT, then JMPF target 0x100 -> flags 1, 0; the JMPF gives out_jump=0, naddr=0. Repeat without the FNOT -> out_jump=1, naddr=0x100.
- Backpressure: stream 4 ADDs with out_ready low for 3 cycles -> in_ready drops after 2 accepts, outputs hold stable, no op is lost or duplicated, results come out in order.
- Illegal opcode 0x3F after CMPEQ (equal) -> out_illegal=1, flag stays 1. Reset asserted while 2 ops are in flight -> neither op appears at the output.
